pattern_det: RTL and testbench
==============================

// Module: pattern_det
// PURPOSE
//  Runtime-programmable serial bit-pattern detector; parametrised successor of the fixed 1-0-1 FSM detector.
//  Matches a masked pattern of 1..MAX_LEN bits on a qualified serial stream, in overlapping or non-overlapping mode.
//  Optional saturating match counter. Sits on serial/protocol front-ends (framing, sync-word search).
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (legal 2..32)
//  CNT_W    16  match counter width (used only with PATTERN_DET_COUNT_EN)
// PORTS
//  clk          in   1                     clock; all logic on posedge
//  rst          in   1                     synchronous, active-high reset
//  din_valid    in   1                     din is sampled this cycle
//  din          in   1                     serial data bit
//  cfg_load     in   1                     latch cfg_* this cycle; clears match history
//  cfg_pattern  in   MAX_LEN               pattern; bit[len-1] = first bit received, bit[0] = last
//  cfg_mask     in   MAX_LEN               1 = compare bit, 0 = don't-care
//  cfg_len      in   $clog2(MAX_LEN+1)     pattern length
//  cfg_overlap  in   1                     1 = overlapping matches allowed
//  detected     out  1                     one-cycle match pulse
//  armed        out  1                     >= len-1 valid bits held (next valid bit can match)
//  count_clr    in   1                     clear match_count (macro only)
//  match_count  out  CNT_W                 saturating match count (macro only)
// BEHAVIOUR
//  - Reset: hist=0, fill=0, state=EMPTY, pattern/mask/len/overlap regs=0, detected=0, armed=0, match_count=0.
//  - len=0 after reset: no match ever until a cfg_load with cfg_len>=1.
//  - cfg_load: regs <= cfg_*; hist<=0; fill<=0; state<=EMPTY; detected<=0 next cycle.
//    cfg_len > MAX_LEN clamps to MAX_LEN. A din_valid bit in the cfg_load cycle is discarded.
//  - Accept (din_valid & !cfg_load): hist <= {hist[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN).
//  - Match in an accept cycle iff len>=1, fill+1 >= len and
//    ((hist_next ^ pattern) & mask & lenmask) == 0, where lenmask = low len bits set.
//  - detected registered: high exactly the cycle after the matching bit is accepted; latency 1 clk.
//    Never high two consecutive cycles unless two consecutive accepted bits each complete a match
//    (overlap=1, len=1 or periodic patterns).
//  - Non-overlap (overlap=0): on match, fill <= 0, so the next match needs len fresh bits.
//    Overlap=1: fill keeps saturating; back-to-back matches are permitted.
//  - FSM (state reg, 2 bits):
//      EMPTY   fill==0;        accept -> FILLING, or -> ARMED if len<=2
//      FILLING 0<fill<len-1;   accept -> ARMED when fill+1 == len-1
//      ARMED   fill>=len-1;    match & !overlap -> EMPTY; otherwise stays ARMED
//      cfg_load from any state -> EMPTY.
//    armed = (state==ARMED), registered.
//  - din_valid=0 holds all state; gaps in the stream are transparent.
//  - rst overrides cfg_load, din_valid and count_clr in the same cycle.
// CONFIGURATION
//  `PATTERN_DET_COUNT_EN defined:
//    - match_count increments on each match and saturates at 2^CNT_W-1.
//    - count_clr zeroes it next cycle; if clr and a match occur together, clear wins (count=0).
//    - cfg_load does NOT clear the count.
//  Undefined: count_clr ignored; match_count tied to 0; no counter flops.
// TESTING
//  1. len=3, pat=3'b101, mask=3'b111, overlap=1; stream 1,0,1,0,1 -> detected after bits 3 and 5 only.
//  2. Same config, overlap=0; stream 1,0,1,0,1 -> detected after bit 3 only; armed=0 cycle after pulse.
//  3. len=3, pat=101, mask=101; stream 1,1,1 -> detected after bit 3.
//     din_valid gap of 4 cycles mid-stream -> same result.
//  4. len=4, pat=1101; feed 1,1,0, then cfg_load (len=2, pat=01) with din=1 valid ->
//     bit dropped, no pulse; then 0,1 -> detected.
//  5. COUNT_EN, CNT_W=2, len=1, pat=1, overlap=1; 5 ones -> match_count 1,2,3,3,3;
//     count_clr with a simultaneous match -> 0.
//  6. Assert rst while ARMED with a matching bit valid -> detected=0 next cycle, armed=0, match_count=0.

Source files
------------

// File: rtl/pattern_det.sv
// rtl/pattern_det.sv - runtime-programmable masked serial bit-pattern detector
// Optional saturating match counter enabled by defining PATTERN_DET_COUNT_EN.
module pattern_det #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic                         din,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [MAX_LEN-1:0]           cfg_mask,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         detected,
  output logic                         armed,
  input  logic                         count_clr,
  output logic [CNT_W-1:0]             match_count
);

  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   ONE_W    = (LEN_W+1)'(1);

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, ARMED = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               det_q, det_d;

  logic [MAX_LEN-1:0] lenmask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W:0]     fill_p1;
  logic [LEN_W:0]     len_m1;
  logic               match;

  // Next-state logic: config latch, history shift, match evaluation and FSM transitions.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    len_d     = len_q;
    fill_d    = fill_q;
    ovl_d     = ovl_q;
    det_d     = 1'b0;
    match     = 1'b0;
    lenmask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenmask[i] = (i < int'(len_q));
    end
    hist_next = {hist_q[MAX_LEN-2:0], din};
    fill_p1   = {1'b0, fill_q} + ONE_W;
    len_m1    = {1'b0, len_q} - ONE_W;

    if (cfg_load) begin
      // A bit arriving with the load belongs to the old configuration and is dropped.
      pat_d   = cfg_pattern;
      mask_d  = cfg_mask;
      len_d   = (cfg_len > FILL_MAX) ? FILL_MAX : cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (din_valid) begin
      hist_d = hist_next;
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_p1[LEN_W-1:0];
      match  = (len_q != '0) && (fill_p1 >= {1'b0, len_q}) &&
               (((hist_next ^ pat_q) & mask_q & lenmask) == '0);
      det_d  = match;
      if (match && !ovl_q) begin
        // Non-overlapping: the next match must be built entirely from fresh bits.
        fill_d  = '0;
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY:   state_d = (len_q <= LEN_W'(2)) ? ARMED : FILLING;
          FILLING: state_d = (fill_p1 == len_m1) ? ARMED : FILLING;
          ARMED:   state_d = ARMED;
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Datapath and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      pat_q  <= '0;
      mask_q <= '0;
      len_q  <= '0;
      fill_q <= '0;
      ovl_q  <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      fill_q <= fill_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
    end
  end

  assign detected = det_q;
  assign armed    = (state_q == ARMED);

`ifdef PATTERN_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter; clear has priority over a coincident match.
  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (count_clr)               cnt_q <= '0;
    else if (match && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_count = cnt_q;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_pattern_det.sv
// tb/tb_pattern_det.sv - randomized self-checking bench for pattern_det against a bit-queue model
module tb_pattern_det;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [7:0] cfg_mask = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       count_clr = 1'b0;
  logic       detected;
  logic       armed;
  logic [1:0] match_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         bits_q[$];
  int         m_fill = 0;
  int         m_len = 0;
  logic [7:0] m_pat = '0;
  logic [7:0] m_mask = '0;
  bit         m_ovl = 0;
  bit         m_det = 0;
  int         m_cnt = 0;

  pattern_det #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .detected(detected), .armed(armed),
    .count_clr(count_clr), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit m_match;
    m_match = 0;
    if (rst) begin
      bits_q.delete();
      m_fill = 0; m_len = 0; m_pat = '0; m_mask = '0; m_ovl = 0; m_det = 0; m_cnt = 0;
    end else begin
      if (cfg_load) begin
        m_len  = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
        m_pat  = cfg_pattern;
        m_mask = cfg_mask;
        m_ovl  = cfg_overlap;
        bits_q.delete();
        m_fill = 0;
        m_det  = 0;
      end else if (din_valid) begin
        bits_q.push_back(din);
        if (bits_q.size() > 32) void'(bits_q.pop_front());
        if (m_len >= 1 && m_fill + 1 >= m_len) begin
          m_match = 1;
          for (int k = 0; k < m_len; k++) begin
            if (m_mask[k] && (bits_q[bits_q.size()-1-k] != m_pat[k])) m_match = 0;
          end
        end
        if (m_fill < 8) m_fill++;
        if (m_match && !m_ovl) m_fill = 0;
        m_det = m_match;
      end else begin
        m_det = 0;
      end
`ifdef PATTERN_DET_COUNT_EN
      if (count_clr) m_cnt = 0;
      else if (m_match && m_cnt < 3) m_cnt++;
`endif
    end
  endtask

  task automatic tick();
    int exp_armed;
    model_step();
    @(posedge clk);
    #1;
    exp_armed = (m_fill != 0 && m_fill + 1 >= m_len) ? 1 : 0;
    chk("detected", int'(detected), int'(m_det));
    chk("armed", int'(armed), exp_armed);
    chk("match_count", int'(match_count), m_cnt);
  endtask

  task automatic bit_in(input bit v, input bit d);
    din_valid = v; din = d; cfg_load = 0; count_clr = 0;
    tick();
  endtask

  task automatic load(input int len, input logic [7:0] pat, input logic [7:0] mask,
                      input bit ovl, input bit v, input bit d);
    cfg_load = 1; cfg_len = 4'(len); cfg_pattern = pat; cfg_mask = mask;
    cfg_overlap = ovl; din_valid = v; din = d; count_clr = 0;
    tick();
    cfg_load = 0; din_valid = 0;
  endtask

  bit t_stream[5];
  bit t1_exp[5];
  int t5_exp[5];

  initial begin
    // reset state
    rst = 1;
    model_step();
    @(posedge clk); #1;
    tick();
    chk("rst_detected", int'(detected), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_count", int'(match_count), 0);
    rst = 0;

    // len=0 after reset: nothing matches
    for (int i = 0; i < 6; i++) bit_in(1, 1'(i));
    chk("len0_nomatch", int'(detected), 0);

    // 1. overlapping 101 on 1,0,1,0,1
    t_stream = '{1, 0, 1, 0, 1};
    t1_exp   = '{0, 0, 1, 0, 1};
    load(3, 8'b101, 8'b111, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bit_in(1, t_stream[i]);
      chk("t1_pulse", int'(detected), int'(t1_exp[i]));
    end

    // 2. non-overlapping: only the first pulse, armed drops with it
    load(3, 8'b101, 8'b111, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bit_in(1, t_stream[i]);
      chk("t2_pulse", int'(detected), (i == 2) ? 1 : 0);
      if (i == 2) chk("t2_armed", int'(armed), 0);
    end

    // 3. masked middle bit, with and without a 4-cycle gap
    load(3, 8'b101, 8'b101, 1, 0, 0);
    bit_in(1, 1); bit_in(1, 1); bit_in(1, 1);
    chk("t3_pulse", int'(detected), 1);
    load(3, 8'b101, 8'b101, 1, 0, 0);
    bit_in(1, 1); bit_in(1, 1);
    for (int i = 0; i < 4; i++) bit_in(0, 0);
    bit_in(1, 1);
    chk("t3_gap_pulse", int'(detected), 1);

    // 4. reload mid-stream drops the coincident bit
    load(4, 8'b1101, 8'hFF, 0, 0, 0);
    bit_in(1, 1); bit_in(1, 1); bit_in(1, 0);
    load(2, 8'b01, 8'hFF, 0, 1, 1);
    chk("t4_load_nopulse", int'(detected), 0);
    bit_in(1, 0);
    chk("t4_after0", int'(detected), 0);
    bit_in(1, 1);
    chk("t4_pulse", int'(detected), 1);

    // clamp: cfg_len above MAX_LEN acts as 8
    load(12, 8'hA5, 8'hFF, 0, 0, 0);
    for (int i = 7; i >= 0; i--) bit_in(1, 1'((8'hA5 >> i) & 1));
    chk("clamp_pulse", int'(detected), 1);

    // 5. saturating counter and clear-wins
`ifdef PATTERN_DET_COUNT_EN
    t5_exp = '{1, 2, 3, 3, 3};
`else
    t5_exp = '{0, 0, 0, 0, 0};
`endif
    load(1, 8'b1, 8'hFF, 1, 0, 0);
    count_clr = 1; din_valid = 0; tick(); count_clr = 0;
    for (int i = 0; i < 5; i++) begin
      bit_in(1, 1);
      chk("t5_count", int'(match_count), t5_exp[i]);
    end
    din_valid = 1; din = 1; count_clr = 1; tick(); count_clr = 0;
    chk("t5_clr_wins", int'(match_count), 0);
    chk("t5_clr_pulse", int'(detected), 1);

    // 6. reset while armed with a matching bit pending
    load(2, 8'b11, 8'hFF, 1, 0, 0);
    bit_in(1, 1); bit_in(1, 1);
    bit_in(1, 1);
    chk("t6_armed_before", int'(armed), 1);
    rst = 1; din_valid = 1; din = 1; cfg_load = 1; count_clr = 0;
    tick();
    chk("t6_detected", int'(detected), 0);
    chk("t6_armed", int'(armed), 0);
    chk("t6_count", int'(match_count), 0);
    rst = 0; cfg_load = 0;

    // randomized segments
    for (int s = 0; s < 24; s++) begin
      int len;
      logic [7:0] msk;
      len = (s % 6 == 5) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 5));
      msk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      load(len, 8'($urandom), msk, 1'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; c < 120; c++) begin
        din_valid   = ($urandom_range(0, 3) != 0);
        din         = 1'($urandom);
        count_clr   = ($urandom_range(0, 15) == 0);
        cfg_load    = ($urandom_range(0, 63) == 0);
        rst         = ($urandom_range(0, 199) == 0);
        cfg_len     = 4'($urandom_range(0, 9));
        cfg_pattern = 8'($urandom);
        cfg_mask    = 8'($urandom) | 8'h0F;
        cfg_overlap = 1'($urandom);
        tick();
      end
      rst = 0; cfg_load = 0; count_clr = 0; din_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
